spi_pad_master: RTL and testbench
=================================

# spi_pad_master

SPI master controller that sequences the SPI pad group of the ysyx IP slot: SCK, eight active-low slave selects, MOSI and MISO. Requesters hand it one transfer at a time over a valid/ready command port. It runs the serial shift in SPI mode 0 (CPOL=0, CPHA=0, MSB first) and returns the received word on a valid/ready response port. Its outputs feed the pad-output mux of the top level, and `spi_miso_i` comes from the MISO input pad.

## Interface
- `MAX_BITS`, 32: maximum transfer length in bits; sets the width of the data ports.
- `DIV_W`, 8: width of the clock-divider input.
- `clk_i` input 1: single clock.
- `rst_i` input 1: synchronous, active-high reset.
- `req_valid_i` input 1: command valid.
- `req_ready_o` output 1: command accepted when `req_valid_i && req_ready_o` at a rising edge.
- `req_ss_i` input 3: index of the slave select to assert.
- `req_len_i` input 6: bit count. 0 and 33..63 mean 32.
- `req_data_i` input MAX_BITS: TX word, right-aligned. Bits above len-1 are ignored.
- `clk_div_i` input DIV_W: half-period H = `clk_div_i`+1 clk cycles.
- `rsp_valid_o` output 1: RX word valid.
- `rsp_ready_i` input 1: response consumed.
- `rsp_data_o` output MAX_BITS: RX word, right-aligned, upper bits zero.
- `busy_o` output 1: state ≠ IDLE.
- `spi_sck_o` output 1: serial clock.
- `spi_ss_o` output 8: slave selects, active low, at most one low.
- `spi_mosi_o` output 1: serial data out.
- `spi_miso_i` input 1: serial data in. Sampled directly, no synchronizer.

## Operation
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, RESP.
- IDLE: `req_ready_o`=1.
  - On accept, latch ss index, effective len, TX word and H.
  - Clear RX shift register and bit counter.
  - Go to SETUP.
  - Later changes on the request inputs or `clk_div_i` have no effect on the running transfer.
- SETUP (H cycles): selected `spi_ss_o` bit low, SCK=0, MOSI=TX[len-1]. Then go to SCK_HI.
- Entry into SCK_HI (the SCK rising edge):
  - shift `spi_miso_i` into RX LSB;
  - increment the bit counter.
  - SCK_HI lasts H cycles.
- SCK_HI exit:
  - if count==len, go to HOLD;
  - else go to SCK_LO: SCK=0, MOSI advances to the next lower TX bit. SCK_LO lasts H cycles, then go to SCK_HI.
- HOLD (H cycles): SCK=0, SS still asserted, MOSI holds the last bit.
- RESP:
  - on entry, `spi_ss_o`=8'hFF, MOSI=0, `rsp_valid_o`=1, `rsp_data_o`=RX;
  - remain until `rsp_ready_i`=1, then go to IDLE;
  - `req_ready_o`=0 throughout.
- `rsp_data_o` holds its value after the handshake until the next transfer completes.
- Divider: one down-counter of DIV_W bits, reloaded with H-1 on every phase entry. A phase ends on the cycle the counter reaches 0.

## Timing
- Reset (`rst_i`=1 at an edge) forces, from the next cycle:
  - state IDLE;
  - `spi_sck_o`=0, `spi_ss_o`=8'hFF, `spi_mosi_o`=0;
  - `rsp_valid_o`=0, `rsp_data_o`=0, `busy_o`=0.
- `req_ready_o`=0 while `rst_i`=1.
- Reset mid-transfer aborts immediately. The partial response is discarded and the SS bit deasserts on the next edge.
- Accept at edge T0:
  - SS low and `busy_o`=1 from cycle T0+1;
  - first SCK rise at T0+1+H;
  - SCK period 2H;
  - `rsp_valid_o` rises at T0+1+(2·len+1)·H.
- Example: len=8, H=1 gives `rsp_valid_o` at T0+18.
- Back-to-back transfers:
  - the response handshake at edge T1 puts IDLE at T1+1;
  - a new accept is possible at edge T1+1;
  - SS stays high for at least 2 cycles between transfers.
- All outputs are registered. There are no combinational paths from the request inputs to the SPI pins.

## Test plan
- Reset: hold `rst_i` 3 cycles, release.
  - During reset: SS=8'hFF, SCK=0, ready=0.
  - Cycle after release: ready=1.
- Basic transfer: ss=2, len=8, data=8'hA5, div=0, MISO loopback from MOSI.
  - `spi_ss_o`=8'hFB from T0+1.
  - 8 SCK pulses, MOSI pattern 1,0,1,0,0,1,0,1.
  - `rsp_valid_o` at T0+18 with data 32'h000000A5.
- Divider and length:
  - len=0 (32 bits), data=32'hDEADBEEF, div=3, MISO tied 1.
  - SCK high 4 cycles and low 4 cycles.
  - Response 32'hFFFFFFFF at T0+1+65·4.
- Response backpressure: hold `rsp_ready_i`=0 for 10 cycles after `rsp_valid_o`.
  - valid and data stay stable, SS stays 8'hFF, `req_ready_o`=0.
  - Handshake, then ready=1 on the next cycle.
- Mid-transfer reset: assert `rst_i` after the 3rd SCK rise.
  - Next cycle: SS=8'hFF, SCK=0, `rsp_valid_o`=0.
  - A following transfer completes normally.
- Latching: change `req_data_i`, `req_ss_i` and `clk_div_i` one cycle after accept.
  - The transfer uses the originally latched values.

Source files
------------

// File: rtl/spi_pad_master.sv
// spi_pad_master: SPI mode-0 master (CPOL=0, CPHA=0, MSB first) driving the
// SPI pad group (SCK, eight active-low selects, MOSI, MISO).
// One transfer at a time is taken on a valid/ready command port. The received
// word is returned on a valid/ready response port.
//
// Ports
//   clk_i, rst_i          single clock, synchronous active-high reset
//   req_valid_i/ready_o   command handshake
//   req_ss_i              select index (0..7)
//   req_len_i             bit count, 0 or >MAX_BITS means MAX_BITS
//   req_data_i            TX word, right-aligned
//   clk_div_i             SCK half period H = clk_div_i + 1 clk cycles
//   rsp_valid_o/ready_i   response handshake
//   rsp_data_o            RX word, right-aligned, upper bits zero
//   busy_o                transfer in progress (state != IDLE)
//   spi_sck_o, spi_ss_o, spi_mosi_o, spi_miso_i   pad-side SPI signals
//
// state  | meaning
// IDLE   | waiting for a command, req_ready_o high
// SETUP  | SS asserted, first MOSI bit presented, SCK low for H cycles
// SCK_HI | SCK high for H cycles; MISO was sampled on entry
// SCK_LO | SCK low for H cycles; MOSI moved to next bit on entry
// HOLD   | SCK low, SS still asserted, last MOSI bit held for H cycles
// RESP   | SS released, response valid until consumed

module spi_pad_master #(
  parameter int MAX_BITS = 32,
  parameter int DIV_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [2:0]          req_ss_i,
  input  logic [5:0]          req_len_i,
  input  logic [MAX_BITS-1:0] req_data_i,
  input  logic [DIV_W-1:0]    clk_div_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [MAX_BITS-1:0] rsp_data_o,
  output logic                busy_o,
  output logic                spi_sck_o,
  output logic [7:0]          spi_ss_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i
);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, RESP} state_t;

  state_t              state, state_next;
  logic [DIV_W-1:0]    div_q, div_cnt;
  logic [5:0]          len_q, bit_cnt, len_eff;
  logic [MAX_BITS-1:0] tx_sh, rx_sh, tx_aligned;
  logic                phase_done;

  assign phase_done = (div_cnt == '0);

  assign len_eff = (req_len_i == 6'd0 || req_len_i > 6'(MAX_BITS)) ? 6'(MAX_BITS) : req_len_i;

  // TX word is left-aligned so the next MOSI bit is always the shifter MSB.
  assign tx_aligned = req_data_i << (7'(MAX_BITS) - {1'b0, len_eff});

  // Ready is gated by reset so a command presented during reset is never taken.
  assign req_ready_o = (state == IDLE) && !rst_i;
  assign busy_o      = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid_i) state_next = SETUP;
      SETUP:   if (phase_done)  state_next = SCK_HI;
      SCK_HI:  if (phase_done)  state_next = (bit_cnt == len_q) ? HOLD : SCK_LO;
      SCK_LO:  if (phase_done)  state_next = SCK_HI;
      HOLD:    if (phase_done)  state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      spi_sck_o   <= 1'b0;
      spi_ss_o    <= 8'hFF;
      spi_mosi_o  <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      div_q       <= '0;
      div_cnt     <= '0;
      len_q       <= '0;
      bit_cnt     <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
    end else begin
      state <= state_next;

      // Every phase change reloads the divider with H-1; from IDLE the
      // divider value is taken straight from the command being accepted.
      if (state_next != state)
        div_cnt <= (state == IDLE) ? clk_div_i : div_q;
      else if (!phase_done)
        div_cnt <= div_cnt - DIV_W'(1);

      case (state)
        IDLE: if (state_next == SETUP) begin
          div_q      <= clk_div_i;
          len_q      <= len_eff;
          tx_sh      <= tx_aligned;
          rx_sh      <= '0;
          bit_cnt    <= '0;
          spi_ss_o   <= ~(8'b1 << req_ss_i);
          spi_mosi_o <= tx_aligned[MAX_BITS-1];
        end
        SETUP, SCK_LO: if (state_next == SCK_HI) begin
          spi_sck_o <= 1'b1;
          rx_sh     <= {rx_sh[MAX_BITS-2:0], spi_miso_i};
          bit_cnt   <= bit_cnt + 6'd1;
        end
        SCK_HI: begin
          if (state_next == SCK_LO) begin
            spi_sck_o  <= 1'b0;
            tx_sh      <= tx_sh << 1;
            spi_mosi_o <= tx_sh[MAX_BITS-2];
          end else if (state_next == HOLD) begin
            spi_sck_o <= 1'b0;
          end
        end
        HOLD: if (state_next == RESP) begin
          spi_ss_o    <= 8'hFF;
          spi_mosi_o  <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_data_o  <= rx_sh;
        end
        RESP: if (state_next == IDLE) rsp_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pad_master.sv
// Testbench for spi_pad_master. Expected pin activity is computed per cycle
// from the transfer parameters (phase index = (cycle-1)/H) and the expected
// RX word from the MISO source, independently of the RTL's structure.

module tb_spi_pad_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_ss_i;
  logic [5:0]  req_len_i;
  logic [31:0] req_data_i;
  logic [7:0]  clk_div_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        busy_o;
  logic        spi_sck_o;
  logic [7:0]  spi_ss_o;
  logic        spi_mosi_o;
  logic        spi_miso_i;

  int checks = 0;
  int errors = 0;

  spi_pad_master #(.MAX_BITS(32), .DIV_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ss_i(req_ss_i), .req_len_i(req_len_i), .req_data_i(req_data_i),
    .clk_div_i(clk_div_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o),
    .spi_sck_o(spi_sck_o), .spi_ss_o(spi_ss_o), .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(spi_miso_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One complete transfer with per-cycle pin checks.
  // abort_at > 0 asserts reset once that many SCK rises have been seen.
  task automatic do_xfer(input logic [2:0] ss, input logic [5:0] len_in,
                         input logic [31:0] data, input logic [7:0] div,
                         input bit loopback, input logic [31:0] miso_word,
                         input int bp, input int abort_at);
    int len, h, d_rsp, p, k, rises;
    bit prev_sck, ready_seen;
    logic [7:0]  exp_ss;
    logic [31:0] mask, exp_rx;

    len    = (len_in == 6'd0 || len_in > 6'd32) ? 32 : int'(len_in);
    h      = int'(div) + 1;
    d_rsp  = 1 + (2 * len + 1) * h;
    exp_ss = ~(8'h01 << ss);
    mask   = (len == 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
    exp_rx = (loopback ? data : miso_word) & mask;

    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_ss_i    = ss;
    req_len_i   = len_in;
    req_data_i  = data;
    clk_div_i   = div;
    ready_seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready_o) begin
        ready_seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!ready_seen) begin
      check("req_ready_timeout", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);

    rises    = 0;
    prev_sck = 1'b0;
    for (int d = 1; d < d_rsp; d++) begin
      @(negedge clk_i);
      if (d == 1) begin
        // Scramble the request inputs: the running transfer must ignore them.
        req_valid_i = 1'b0;
        req_ss_i    = ~ss;
        req_len_i   = ~len_in;
        req_data_i  = ~data;
        clk_div_i   = ~div;
      end
      if (spi_sck_o && !prev_sck) rises++;
      prev_sck   = spi_sck_o;
      spi_miso_i = loopback ? spi_mosi_o : (rises < len ? miso_word[len-1-rises] : 1'b0);

      p = (d - 1) / h;
      k = (p / 2 > len - 1) ? len - 1 : p / 2;
      check("ss",        32'(spi_ss_o),    32'(exp_ss));
      check("sck",       32'(spi_sck_o),   32'(p % 2 == 1 && p < 2 * len));
      check("mosi",      32'(spi_mosi_o),  32'(data[len-1-k]));
      check("busy",      32'(busy_o),      32'd1);
      check("rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("req_ready", 32'(req_ready_o), 32'd0);

      if (abort_at > 0 && rises == abort_at) begin
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_ss",        32'(spi_ss_o),    32'hFF);
        check("abort_sck",       32'(spi_sck_o),   32'd0);
        check("abort_mosi",      32'(spi_mosi_o),  32'd0);
        check("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("abort_rsp_data",  rsp_data_o,       32'd0);
        check("abort_busy",      32'(busy_o),      32'd0);
        check("abort_req_ready", 32'(req_ready_o), 32'd0);
        rst_i      = 1'b0;
        spi_miso_i = 1'b0;
        return;
      end
    end

    @(negedge clk_i);
    check("rsp_valid_rise", 32'(rsp_valid_o), 32'd1);
    check("rsp_data",       rsp_data_o,       exp_rx);
    check("resp_ss",        32'(spi_ss_o),    32'hFF);
    check("resp_sck",       32'(spi_sck_o),   32'd0);
    check("resp_mosi",      32'(spi_mosi_o),  32'd0);
    check("resp_busy",      32'(busy_o),      32'd1);
    check("resp_req_ready", 32'(req_ready_o), 32'd0);

    for (int i = 0; i < bp; i++) begin
      @(negedge clk_i);
      check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_rsp_data",  rsp_data_o,       exp_rx);
      check("bp_ss",        32'(spi_ss_o),    32'hFF);
      check("bp_req_ready", 32'(req_ready_o), 32'd0);
    end

    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("post_req_ready", 32'(req_ready_o), 32'd1);
    check("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("post_busy",      32'(busy_o),      32'd0);
    check("post_rsp_hold",  rsp_data_o,       exp_rx);
    check("post_ss",        32'(spi_ss_o),    32'hFF);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_ss_i    = '0;
    req_len_i   = '0;
    req_data_i  = '0;
    clk_div_i   = '0;
    rsp_ready_i = 1'b0;
    spi_miso_i  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst_ss",        32'(spi_ss_o),    32'hFF);
      check("rst_sck",       32'(spi_sck_o),   32'd0);
      check("rst_req_ready", 32'(req_ready_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_busy",      32'(busy_o),      32'd0);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rel_req_ready", 32'(req_ready_o), 32'd1);
    check("rel_rsp_data",  rsp_data_o,       32'd0);
    check("rel_mosi",      32'(spi_mosi_o),  32'd0);

    // Basic: ss=2, 8 bits of A5, H=1, loopback
    do_xfer(3'd2, 6'd8, 32'h0000_00A5, 8'd0, 1'b1, 32'd0, 0, 0);
    // 32-bit via len=0, H=4, MISO tied high
    do_xfer(3'd5, 6'd0, 32'hDEAD_BEEF, 8'd3, 1'b0, 32'hFFFF_FFFF, 0, 0);
    // Response backpressure for 10 cycles
    do_xfer(3'd7, 6'd16, $urandom, 8'd1, 1'b0, $urandom, 10, 0);
    // Reset after the 3rd SCK rise, then a normal transfer (len 33 -> 32)
    do_xfer(3'd1, 6'd12, $urandom, 8'd0, 1'b1, 32'd0, 0, 3);
    do_xfer(3'd0, 6'd33, $urandom, 8'd0, 1'b0, $urandom, 0, 0);
    // Single-bit boundary
    do_xfer(3'd4, 6'd1, 32'h0000_0001, 8'd2, 1'b1, 32'd0, 1, 0);

    for (int n = 0; n < 12; n++) begin
      do_xfer(3'($urandom), 6'($urandom_range(0, 63)), $urandom,
              8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
